// File: rtl/seq_div.sv
// Sequential 32-bit signed/unsigned divider: restoring radix-2, one quotient bit per cycle,
// 33-cycle latency from the start edge to valid q/r with a one-cycle ready pulse.
module seq_div (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic        sign_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] q_o,
   output logic [31:0] r_o,
   output logic        busy_o,
   output logic        ready_o,
   output logic        dz_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] araw_q, araw_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rmd_q, rmd_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        busy_q, busy_d;
   logic        ready_q, ready_d;
   logic        dz_q, dz_d;
   logic [32:0] shift_s;
   logic [32:0] diff_s;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic s);
      return (s && v[31]) ? neg32(v) : v;
   endfunction

   // Next-state and datapath: capture in IDLE, one restoring step per RUN cycle, sign fix in FIX
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      araw_d  = araw_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      busy_d  = busy_q;
      ready_d = 1'b0;
      dz_d    = dz_q;
      shift_s = {rem_q, dvd_q[31]};
      diff_s  = shift_s - {1'b0, dvs_q};

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
               cnt_d   = 5'd0;
               busy_d  = 1'b1;
               rem_d   = 32'd0;
               dvd_d   = mag32(a_i, sign_i);
               dvs_d   = mag32(b_i, sign_i);
               araw_d  = a_i;
               qneg_d  = sign_i & (a_i[31] ^ b_i[31]);
               rneg_d  = sign_i & a_i[31];
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // Non-negative trial difference keeps the subtraction; the remainder stays below |b|
            if (!diff_s[32]) begin
               rem_d = diff_s[31:0];
               dvd_d = {dvd_q[30:0], 1'b1};
            end else begin
               rem_d = shift_s[31:0];
               dvd_d = {dvd_q[30:0], 1'b0};
            end
            if (cnt_q == 5'd31) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         FIX: begin
            if (dvs_q == 32'd0) begin
               quo_d = 32'hFFFF_FFFF;
               rmd_d = araw_q;
               dz_d  = 1'b1;
            end else begin
               quo_d = qneg_q ? neg32(dvd_q) : dvd_q;
               rmd_d = rneg_q ? neg32(rem_q) : rem_q;
               dz_d  = 1'b0;
            end
            state_d = IDLE;
            cnt_d   = 5'd0;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 5'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         rem_q   <= 32'd0;
         dvd_q   <= 32'd0;
         dvs_q   <= 32'd0;
         araw_q  <= 32'd0;
         quo_q   <= 32'd0;
         rmd_q   <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         araw_q  <= araw_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         dz_q    <= dz_d;
      end
   end

   assign q_o     = quo_q;
   assign r_o     = rmd_q;
   assign busy_o  = busy_q;
   assign ready_o = ready_q;
   assign dz_o    = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed vector table, hand-written corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_seq_div;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic        sign_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [31:0] q_o;
   logic [31:0] r_o;
   logic        busy_o;
   logic        ready_o;
   logic        dz_o;

   int checks = 0;
   int errors = 0;

   seq_div dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .start_i (start_i),
      .sign_i  (sign_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .q_o     (q_o),
      .r_o     (r_o),
      .busy_o  (busy_o),
      .ready_o (ready_o),
      .dz_o    (dz_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: plain signed/unsigned division with the divide-by-zero and overflow rules
   task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      dz = 1'b0;
      if (b == 32'd0) begin
         q  = 32'hFFFF_FFFF;
         r  = a;
         dz = 1'b1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (s) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // Called at a negedge; returns at the negedge where ready is seen (or after the bound)
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int inj,
                         output logic [31:0] gq, output logic [31:0] gr, output logic gdz,
                         output int lat, output int busy_cnt);
      sign_i   = s;
      a_i      = a;
      b_i      = b;
      start_i  = 1'b1;
      lat      = -1;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         start_i = (i == inj);
         if (i == inj) begin
            sign_i = 1'b0;
            a_i    = 32'd9;
            b_i    = 32'd3;
         end else begin
            sign_i = 1'($urandom_range(0, 1));
            a_i    = $urandom;
            b_i    = $urandom;
         end
         if (busy_o) busy_cnt++;
         if (ready_o) begin
            lat = i;
            break;
         end
      end
      start_i = 1'b0;
      gq  = q_o;
      gr  = r_o;
      gdz = dz_o;
   endtask

   task automatic do_check(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int inj, input logic [31:0] eq, input logic [31:0] er, input logic edz);
      logic [31:0] gq;
      logic [31:0] gr;
      logic        gdz;
      int          lat;
      int          bc;
      run_op(s, a, b, inj, gq, gr, gdz, lat, bc);
      chk({tag, ".q"}, gq, eq);
      chk({tag, ".r"}, gr, er);
      chk({tag, ".dz"}, {31'd0, gdz}, {31'd0, edz});
      chk({tag, ".latency"}, 32'(lat), 32'd33);
      chk({tag, ".busy_cycles"}, 32'(bc), 32'd33);
   endtask

   initial begin
      logic [31:0] eq;
      logic [31:0] er;
      logic        edz;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      int          rdy_cnt;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
      vecs[3]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
      vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
      vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[6]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
      vecs[7]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
      vecs[8]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
      vecs[9]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
      vecs[10] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
      vecs[11] = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          1'b0};

      reset_i = 1'b1;
      start_i = 1'b0;
      sign_i  = 1'b0;
      a_i     = 32'd0;
      b_i     = 32'd0;
      repeat (3) @(negedge clk_i);
      reset_i = 1'b0;
      chk("reset.q", q_o, 32'd0);
      chk("reset.r", r_o, 32'd0);
      chk("reset.flags", {29'd0, busy_o, ready_o, dz_o}, 32'd0);
      @(negedge clk_i);
      chk("idle.flags", {29'd0, busy_o, ready_o, dz_o}, 32'd0);

      // Directed table, issued back-to-back from each ready cycle
      for (int i = 0; i < 12; i++) begin
         do_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, -1,
                  vecs[i].q, vecs[i].r, vecs[i].dz);
      end
      @(negedge clk_i);
      chk("ready_pulse_width", {31'd0, ready_o}, 32'd0);
      chk("idle_busy", {31'd0, busy_o}, 32'd0);
      chk("hold.q", q_o, 32'd0);
      chk("hold.r", r_o, 32'd3);

      // Start during busy ignored, then start in the ready cycle accepted
      do_check("busy_start", 1'b0, 32'd100, 32'd7, 10, 32'd14, 32'd2, 1'b0);
      do_check("ready_start", 1'b0, 32'd9, 32'd3, -1, 32'd3, 32'd0, 1'b0);

      // Reset in the middle of an operation
      sign_i  = 1'b0;
      a_i     = 32'd100;
      b_i     = 32'd7;
      start_i = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk_i);
         start_i = 1'b0;
      end
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0;
      chk("midreset.busy", {31'd0, busy_o}, 32'd0);
      chk("midreset.q", q_o, 32'd0);
      chk("midreset.r", r_o, 32'd0);
      rdy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready_o) rdy_cnt++;
         @(negedge clk_i);
      end
      chk("midreset.no_ready", 32'(rdy_cnt), 32'd0);
      do_check("post_reset", 1'b0, 32'd100, 32'd7, -1, 32'd14, 32'd2, 1'b0);

      // Randomized operations against the reference model
      for (int n = 0; n < 150; n++) begin
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       ra = 32'h8000_0000;
            1:       ra = $urandom_range(0, 50);
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(1, 15);
            3:       rb = $urandom >> $urandom_range(0, 31);
            default: rb = $urandom;
         endcase
         ref_div(rs, ra, rb, eq, er, edz);
         do_check($sformatf("rand%0d", n), rs, ra, rb, -1, eq, er, edz);
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL provide clk, input, 1: single clock; all state changes on rising edge.
REQ-002 SHALL provide reset, input, 1: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL provide start, input, 1: request a division; sampled only in IDLE.
REQ-004 SHALL provide sign, input, 1: 1 = signed (div), 0 = unsigned (divu); captured with start.
REQ-005 SHALL provide a, input, 32: dividend; captured with start.
REQ-006 SHALL provide b, input, 32: divisor; captured with start.
REQ-007 SHALL provide q, output, 32: quotient, registered, feeds LO.
REQ-008 SHALL provide r, output, 32: remainder, registered, feeds HI.
REQ-009 SHALL provide busy, output, 1: high while a division is in progress.
REQ-010 SHALL provide ready, output, 1: one-cycle pulse when q/r become valid.
REQ-011 SHALL provide dz, output, 1: divide-by-zero flag for the last completed operation.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX.
REQ-013 IDLE with start=1 at edge E0 SHALL latch a, b, sign, go to RUN, load iteration counter = 0; busy=1 from E0.
REQ-014 IDLE with start=0 SHALL stay in IDLE; ready SHALL be 0 except the single pulse in REQ-018.
REQ-015 Capture SHALL store |a| and |b| (two's-complement negate when sign=1 and MSB=1); quotient-negative = sign & (a[31]^b[31]); remainder-negative = sign & a[31].
REQ-016 RUN SHALL perform one restoring radix-2 step per cycle: shift {rem,dividend} left 1, trial-subtract |b| from 33-bit rem, keep difference and set quotient bit to 1 if non-negative, else restore and set 0; 32 steps (edges E1..E32), then FIX.
REQ-017 FIX (edge E33) SHALL apply sign correction (negate quotient if quotient-negative, negate remainder if remainder-negative), load q and r, set dz, return to IDLE.
REQ-018 After E33 busy SHALL be 0 and ready SHALL be 1 for exactly one cycle (cleared at E34); total latency start-edge to valid = 33 cycles.
REQ-019 start asserted while busy=1 SHALL be ignored; operands SHALL NOT be re-captured.
REQ-020 start asserted in the cycle ready=1 SHALL be accepted (back-to-back operation).
REQ-021 q and r SHALL hold their last values from FIX until the next FIX; inputs a/b/sign changing during RUN SHALL NOT affect results.
REQ-022 b=0 SHALL keep the 33-cycle latency and produce q=0xFFFFFFFF, r=a (unmodified dividend, both modes), dz=1; otherwise dz=0.
REQ-023 Signed a=0x80000000, b=0xFFFFFFFF SHALL produce q=0x80000000, r=0, dz=0.
REQ-024 Remainder sign SHALL follow dividend; |r| < |b| for b≠0; a = q*b + r (mod 2^32).
REQ-025 No combinational path from inputs to any output.

Reset
REQ-026 reset=1 SHALL force state IDLE, counter=0, q=0, r=0, busy=0, ready=0, dz=0 at the next edge.
REQ-027 reset SHALL take priority over start and over any RUN/FIX activity; an operation interrupted by reset SHALL be abandoned with no ready pulse.
REQ-028 First start after reset deasserts SHALL be accepted normally.

Verification
REQ-029 Unsigned: sign=0, a=100, b=7, start 1 cycle -> busy 33 cycles, ready pulse at cycle 33, q=14, r=2, dz=0.
REQ-030 Signed: sign=1, a=0xFFFFFFF9 (-7), b=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); also a=7, b=0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
REQ-031 Divide by zero: sign=1, a=0x12345678, b=0 -> after 33 cycles q=0xFFFFFFFF, r=0x12345678, dz=1.
REQ-032 Overflow: sign=1, a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0; unsigned a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0.
REQ-033 Start during busy: second start with a=9, b=3 at cycle 10 of a 100/7 op -> ignored, results q=14, r=2; start in ready cycle -> accepted, q=3, r=0 after 33 further cycles.
REQ-034 Reset mid-op: reset at cycle 15 of a division -> next cycle busy=0, q=r=0, no ready pulse; new start afterward completes correctly.
